// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_func.sv
// Glitch-free programmable clock divider: registered Z toggles every DIV+1 cycles.
// Divisor updates and start/stop take effect only at period boundaries (Z falling).
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_func #(
  parameter int unsigned WIDTH = 4
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             BUSY,
  output logic             RUN,
  output logic             Z
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   act_q, act_d;
  logic [WIDTH-1:0]   shd_q, shd_d;
  logic               pend_q, pend_d;
  logic               z_q, z_d;

  logic               term;
  logic               per_end;

  assign term    = (cnt_q == act_q);
  // A period ends on the terminal count of the high phase, i.e. where Z falls.
  assign per_end = (state_q == StRun) && term && z_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      act_q   <= '0;
      shd_q   <= '0;
      pend_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      z_q     <= z_d;
    end
  end

  // Next-state: staging, divisor apply and counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    z_d     = z_q;

    // A request arriving while one is pending (including the apply cycle) is dropped.
    if (LOAD && !pend_q) begin
      shd_d  = DIV;
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        z_d   = 1'b0;
        if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
        if (EN) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (term) begin
          cnt_d = '0;
          z_d   = ~z_q;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
        if (per_end) begin
          if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
          end
          if (!EN) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    RUN  = (state_q == StRun);
    BUSY = pend_q;
    Z    = z_q;
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_func.sv
// Directed bench: stimulus pushes the hand-computed cycle of every Z edge into a queue;
// a negedge monitor pops and compares each observed Z transition.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_func;

  localparam int unsigned W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic         LOAD = 1'b0;
  logic [W-1:0] DIV = '0;
  logic         BUSY;
  logic         RUN;
  logic         Z;

  gf180mcu_fd_sc_mcu9t5v0__clkdiv_func #(
    .WIDTH(W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .DIV (DIV),
    .LOAD(LOAD),
    .BUSY(BUSY),
    .RUN (RUN),
    .Z   (Z)
  );

  always #5 CLK = ~CLK;

  // cyc holds the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic lvl;
    int   at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic prev_z = 1'b0;

  always @(negedge CLK) begin
    if (cyc > 0 && Z !== prev_z) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL z_edge: got Z=%b at cycle %0d, expected no edge", Z, cyc);
      end else begin
        e = q.pop_front();
        if (e.lvl !== Z || e.at != cyc) begin
          errors++;
          $display("FAIL z_edge: got Z=%b at cycle %0d, expected Z=%b at cycle %0d",
                   Z, cyc, e.lvl, e.at);
        end
      end
      prev_z = Z;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic exp_edge(input logic lvl, input int at);
    exp_t x;
    x.lvl = lvl;
    x.at  = at;
    q.push_back(x);
  endtask

  // n_per full periods: rise at first, fall half later, repeat every 2*half.
  task automatic exp_run(input int first, input int half, input int n_per);
    for (int k = 0; k < n_per; k++) begin
      exp_edge(1'b1, first + k * 2 * half);
      exp_edge(1'b0, first + k * 2 * half + half);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    int n;
    int p;
    int m;

    // Reset
    tick();
    tick();
    chk("rst_z", Z, 0);
    chk("rst_run", RUN, 0);
    chk("rst_busy", BUSY, 0);

    // Divide-by-2 straight out of reset
    RST = 1'b0;
    EN  = 1'b1;
    n   = cyc + 1;
    exp_run(n + 1, 1, 3);
    tick();
    chk("d2_run", RUN, 1);
    chk("d2_busy", BUSY, 0);
    chk("d2_z_start", Z, 0);
    wait_cyc(n + 5);
    EN = 1'b0;
    tick();
    chk("d2_stop_run", RUN, 0);
    chk("d2_stop_z", Z, 0);

    // Idle load of DIV=3, then divide-by-8
    LOAD = 1'b1;
    DIV  = 4'd3;
    tick();
    LOAD = 1'b0;
    DIV  = 4'hA;
    chk("idle_load_busy", BUSY, 1);
    tick();
    chk("idle_apply_busy", BUSY, 0);
    EN = 1'b1;
    n  = cyc + 1;
    exp_run(n + 4, 4, 2);
    tick();
    chk("d8_run", RUN, 1);

    // Switch to DIV=1 while Z is high
    wait_cyc(n + 13);
    LOAD = 1'b1;
    DIV  = 4'd1;
    exp_run(n + 18, 2, 2);
    tick();
    LOAD = 1'b0;
    DIV  = 4'h6;
    chk("mid_high_z", Z, 1);
    chk("run_load_busy", BUSY, 1);
    wait_cyc(n + 15);
    chk("run_pend_busy", BUSY, 1);
    tick();
    chk("run_apply_busy", BUSY, 0);

    // Back-to-back loads: 5 accepted, 2 dropped -> divide-by-12
    p = n + 24;
    wait_cyc(p);
    exp_edge(1'b1, p + 2);
    exp_edge(1'b0, p + 4);
    exp_run(p + 10, 6, 2);
    LOAD = 1'b1;
    DIV  = 4'd5;
    tick();
    DIV = 4'd2;
    tick();
    LOAD = 1'b0;
    DIV  = 4'hC;
    chk("b2b_busy", BUSY, 1);
    wait_cyc(p + 4);
    chk("b2b_apply_busy", BUSY, 0);

    // DIV=2 then drop EN one cycle after a rise
    wait_cyc(p + 16);
    LOAD = 1'b1;
    DIV  = 4'd2;
    exp_edge(1'b1, p + 31);
    exp_edge(1'b0, p + 34);
    exp_edge(1'b1, p + 37);
    exp_edge(1'b0, p + 40);
    tick();
    LOAD = 1'b0;
    DIV  = 4'd0;
    chk("d6_load_busy", BUSY, 1);
    wait_cyc(p + 28);
    chk("d6_apply_busy", BUSY, 0);
    wait_cyc(p + 37);
    EN = 1'b0;
    tick();
    chk("stop_req_run", RUN, 1);
    chk("stop_req_z", Z, 1);
    wait_cyc(p + 40);
    chk("stopped_run", RUN, 0);
    chk("stopped_z", Z, 0);
    repeat (5) tick();
    chk("stay_run", RUN, 0);
    chk("stay_z", Z, 0);

    // Reset mid-high with a pending DIV=7
    LOAD = 1'b1;
    DIV  = 4'd7;
    EN   = 1'b1;
    n    = cyc + 1;
    exp_edge(1'b1, n + 3);
    exp_edge(1'b0, n + 5);
    tick();
    LOAD = 1'b0;
    DIV  = 4'd3;
    chk("rst_pre_busy", BUSY, 1);
    chk("rst_pre_run", RUN, 1);
    wait_cyc(n + 4);
    chk("rst_pre_z", Z, 1);
    RST = 1'b1;
    tick();
    chk("rst_mid_z", Z, 0);
    chk("rst_mid_run", RUN, 0);
    chk("rst_mid_busy", BUSY, 0);
    RST = 1'b0;
    m   = n + 6;
    exp_run(m + 1, 1, 2);
    wait_cyc(m + 3);
    EN = 1'b0;
    tick();
    chk("post_rst_run", RUN, 0);
    chk("post_rst_z", Z, 0);

    // Maximum divisor: 16 high, 16 low
    LOAD = 1'b1;
    DIV  = 4'd15;
    tick();
    LOAD = 1'b0;
    DIV  = 4'd1;
    tick();
    EN = 1'b1;
    n  = cyc + 1;
    exp_edge(1'b1, n + 16);
    exp_edge(1'b0, n + 32);
    wait_cyc(n + 31);
    EN = 1'b0;
    chk("max_high_z", Z, 1);
    tick();
    chk("max_stop_run", RUN, 0);
    chk("max_stop_z", Z, 0);

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
